demux1to4_stream: RTL and testbench
===================================

# demux1to4_stream

Registered 1-to-4 stream demultiplexer: the inverse of the team's 4-to-1 select mux. It accepts a single valid/ready input stream tagged with a 2-bit destination select and routes each packet, beat by beat, to one of four output channels. The destination is locked for a whole packet, from its first beat until the beat carrying IN_LAST. It sits between a single producer and four independent consumers that may each apply backpressure.

## Interface
- W, 8, data width per beat (≥1)
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_DATA  input  W  beat payload
- IN_SEL  input  2  destination channel; sampled only on the first beat of a packet
- IN_LAST  input  1  marks final beat of packet
- IN_VALID  input  1  input beat present
- IN_READY  output  1  block can accept a beat this cycle
- OUT_DATA  output  W  payload, shared by all four channels
- OUT_LAST  output  1  last flag, shared
- OUT_VALID  output  4  one-hot valid; bit n = channel n
- OUT_READY  input  4  per-channel consumer ready
- PKT_CNT  output  32  four 8-bit completed-packet counters; channel n occupies bits [8n+7:8n]

## Operation
- Input handshake: a beat is accepted when IN_VALID && IN_READY. Output handshake: a beat is delivered on channel n when OUT_VALID[n] && OUT_READY[n].
- Single-entry output register holds data, last, dest (2b) and a full flag.
- IN_READY = RST_N && (!full || OUT_READY[dest]). It is combinational from OUT_READY and never depends on IN_VALID.
- FSM, 2 states:
  - IDLE: awaiting first beat. On accept, dest_lock = IN_SEL. If IN_LAST=1, stay IDLE; else go to PKT.
  - PKT: IN_SEL is ignored and beats route to dest_lock. Accept with IN_LAST=1 returns to IDLE.
- Register load: on accept, the register takes IN_DATA, IN_LAST and the routing dest (IN_SEL in IDLE, dest_lock in PKT), and full is set.
- Register drain: on output handshake with no same-cycle accept, full is cleared.
- OUT_VALID = full ? (4'b0001 << dest) : 0. At most one bit is ever set.
- OUT_DATA and OUT_LAST hold their last-loaded value when not full.
- PKT_CNT[n] increments by 1 on each output handshake on channel n with OUT_LAST=1. It is 8-bit and wraps 255→0.
- A single-beat packet (IN_LAST on first beat) is legal and counts as one packet.

## Timing
- Reset (async assert, synchronous deassert by the system):
  - FSM=IDLE, full=0, dest=0, dest_lock=0.
  - OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, PKT_CNT=0.
  - IN_READY=0 while RST_N low.
- Latency: a beat accepted at edge k is presented on OUT_* from edge k (after the clock-to-q delay) and can be delivered at edge k+1.
- Throughput: 1 beat/cycle while the destination is ready. Simultaneous drain and load in one cycle is required (pass-through).
- Backpressure: if OUT_READY[dest]=0 with full=1, IN_READY=0. The held beat stays stable; OUT_DATA, OUT_LAST and OUT_VALID must not change until the handshake.
- Ready on a non-destination channel has no effect.
- Packet switch: the first beat of packet B (to a new dest) may be accepted in the same cycle the last beat of packet A drains. No bubble is required.
- Reset mid-packet: the held beat is discarded, the partial packet is abandoned, and the counters are cleared. No OUT_VALID for the discarded beat after reset.

## Structure
- Shared include file holds the FSM state encodings (ST_IDLE=1'b0, ST_PKT=1'b1) and the channel count localparam (NCH=4).
- One natural sub-module: stream_reg_slice, a single-entry valid/ready register slice parameterised on payload width (W+1+2). The demux instantiates it once and decodes the one-hot valid outside it.
- Counters and FSM live in the top module. Target size is 150–250 lines.

## Test plan
- Reset then a single-beat packet: after RST_N rises, drive DATA=8'hA5, SEL=2, LAST=1, OUT_READY=4'hF. Expect OUT_VALID=4'b0100 and OUT_DATA=A5 at the next cycle, and PKT_CNT[2]=1 after delivery.
- Lock across packet: a 3-beat packet with SEL=1,3,0 on successive beats. Expect all beats on OUT_VALID=4'b0010 and only PKT_CNT[1] incremented.
- Backpressure: hold OUT_READY[0]=0 for 5 cycles with a beat for channel 0 full. Expect IN_READY=0 and OUT_DATA stable for 5 cycles, then delivery and IN_READY=1 in the cycle OUT_READY[0] rises.
- Back-to-back packets, no bubble: stream 10 single-beat packets cycling SEL 0→3 with all outputs ready. Expect 10 consecutive deliveries and PKT_CNT = {2,2,3,3} for channels 3..0.
- Wrap: deliver 256 single-beat packets to channel 3. Expect PKT_CNT[3]=0, with the others unaffected.
- Async reset mid-packet: assert RST_N low between beats 2 and 3 of a 4-beat packet. Expect OUT_VALID=0 immediately and FSM=IDLE. After release, the next beat's SEL is honoured.

Source files
------------

// File: rtl/demux1to4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: FSM encodings and channel count.
package demux1to4_stream_pkg;

  localparam int unsigned NCH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register slice; loads and drains in the same cycle for full throughput.
module stream_reg_slice #(
  parameter int unsigned PW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [PW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [PW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready
);

  logic          r_full;
  logic [PW-1:0] r_data;

  assign o_ready = !r_full || i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_ready) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demux: routes whole packets to the channel selected on their first beat
// and counts completed packets per channel.
module demux1to4_stream
  import demux1to4_stream_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [W-1:0]     i_in_data,
  input  logic [1:0]       i_in_sel,
  input  logic             i_in_last,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [W-1:0]     o_out_data,
  output logic             o_out_last,
  output logic [NCH-1:0]   o_out_valid,
  input  logic [NCH-1:0]   i_out_ready,
  output logic [8*NCH-1:0] o_pkt_cnt
);

  localparam int unsigned PW = W + 3;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [1:0]    r_dest_lock;
  logic [1:0]    w_dest_lock_nxt;
  logic [1:0]    w_dest_in;
  logic          w_accept;
  logic          w_slice_ready;
  logic [PW-1:0] w_payload_in;
  logic [PW-1:0] w_payload_out;
  logic          w_full;
  logic [1:0]    w_out_dest;
  logic          w_out_ready_sel;
  logic          w_fire;
  logic [7:0]    r_pkt_cnt [NCH];

  assign o_in_ready = i_rst_n && w_slice_ready;
  assign w_accept   = i_in_valid && o_in_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_dest_lock_nxt = r_dest_lock;
    w_dest_in       = (r_state == ST_IDLE) ? i_in_sel : r_dest_lock;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_dest_lock_nxt = i_in_sel;
          if (!i_in_last) w_state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        if (w_accept && i_in_last) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_dest_lock <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_dest_lock <= w_dest_lock_nxt;
    end
  end

  assign w_payload_in = {i_in_last, w_dest_in, i_in_data};

  stream_reg_slice #(
    .PW (PW)
  ) u_slice (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (w_payload_in),
    .i_valid (i_in_valid),
    .o_ready (w_slice_ready),
    .o_data  (w_payload_out),
    .o_valid (w_full),
    .i_ready (w_out_ready_sel)
  );

  assign {o_out_last, w_out_dest, o_out_data} = w_payload_out;

  // Only the held beat's destination can drain the slice; other channels' ready is ignored.
  assign w_out_ready_sel = i_out_ready[w_out_dest];
  assign w_fire          = w_full && w_out_ready_sel;
  assign o_out_valid     = w_full ? ({{(NCH-1){1'b0}}, 1'b1} << w_out_dest) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCH; i++) r_pkt_cnt[i] <= 8'd0;
    end else if (w_fire && o_out_last) begin
      r_pkt_cnt[w_out_dest] <= r_pkt_cnt[w_out_dest] + 8'd1;
    end
  end

  always_comb begin
    o_pkt_cnt = '0;
    for (int i = 0; i < NCH; i++) o_pkt_cnt[8*i +: 8] = r_pkt_cnt[i];
  end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Self-checking bench for demux1to4_stream: vector table plus scoreboard of expected deliveries.
module tb_demux1to4_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [1:0]  in_sel = 2'd0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'hF;
  logic [31:0] pkt_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] chan;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic       last;
    logic [1:0] exp_chan;
  } vec_t;

  beat_t      sb_q[$];
  vec_t       vecs[13];
  int         n_tests = 0;
  int         n_fail = 0;
  int         stalls = 0;
  logic [1:0] cur_exp = 2'd0;
  logic       accepted = 1'b0;

  demux1to4_stream #(
    .W (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (in_data),
    .i_in_sel    (in_sel),
    .i_in_last   (in_last),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: check any delivery and record any acceptance at the negedge, then step past posedge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (rst_n && |(out_valid & out_ready)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got valid %b data %h, expected no delivery",
                 out_valid, out_data);
      end else begin
        e = sb_q.pop_front();
        chk("deliver", {19'b0, out_valid, out_last, out_data},
            {19'b0, 4'b0001 << e.chan, e.last, e.data});
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      e.data = in_data;
      e.last = in_last;
      e.chan = cur_exp;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l,
                      input logic [1:0] exp);
    int n;
    n = 0;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = 1'b1;
    cur_exp  = exp;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
    end
    stalls += n - 1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h11, 2'd1, 1'b0, 2'd1};
    vecs[1] = '{8'h22, 2'd3, 1'b0, 2'd1};
    vecs[2] = '{8'h33, 2'd0, 1'b1, 2'd1};
    for (int i = 0; i < 10; i++) vecs[3+i] = '{8'(8'h40 + i), 2'(i), 1'b1, 2'(i)};

    // Reset state, with a beat offered to prove ready stays low.
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("rst_out_data", {24'b0, out_data}, 32'h0);
    chk("rst_out_last", {31'b0, out_last}, 32'h0);
    chk("rst_pkt_cnt", pkt_cnt, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Single-beat packet.
    send(8'hA5, 2'd2, 1'b1, 2'd2);
    in_valid = 1'b0;
    chk("single_valid", {28'b0, out_valid}, 32'h4);
    chk("single_data", {24'b0, out_data}, 32'hA5);
    idle(2);
    chk("single_cnt", pkt_cnt, 32'h0001_0000);

    // Destination lock across a 3-beat packet.
    for (int i = 0; i < 3; i++) send(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].exp_chan);
    idle(2);
    chk("lock_cnt", pkt_cnt, 32'h0001_0100);

    // Backpressure on channel 0 while a channel-1 beat waits.
    out_ready = 4'b1110;
    send(8'h5C, 2'd0, 1'b1, 2'd0);
    in_data = 8'h66;
    in_sel  = 2'd1;
    in_last = 1'b1;
    cur_exp = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_data", {24'b0, out_data}, 32'h5C);
      chk("bp_valid", {28'b0, out_valid}, 32'h1);
    end
    out_ready = 4'hF;
    #1;
    chk("bp_release", {31'b0, in_ready}, 32'h1);
    send(8'h66, 2'd1, 1'b1, 2'd1);
    idle(2);
    chk("bp_cnt", pkt_cnt, 32'h0001_0201);

    // Back-to-back single-beat packets from a clean reset.
    do_reset();
    stalls = 0;
    for (int i = 3; i < 13; i++) send(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].exp_chan);
    idle(2);
    chk("b2b_stalls", 32'(stalls), 32'h0);
    chk("b2b_cnt", pkt_cnt, 32'h0202_0303);

    // Channel 3 counter wraps 255->0; other channels untouched.
    for (int i = 0; i < 254; i++) send(8'(i), 2'd3, 1'b1, 2'd3);
    idle(2);
    chk("wrap_zero", pkt_cnt, 32'h0002_0303);
    send(8'hE0, 2'd3, 1'b1, 2'd3);
    send(8'hE1, 2'd3, 1'b1, 2'd3);
    idle(2);
    chk("wrap_cnt", pkt_cnt, 32'h0202_0303);

    // Async reset in the middle of a 4-beat packet with a beat held.
    send(8'hB1, 2'd2, 1'b0, 2'd2);
    send(8'hB2, 2'd2, 1'b0, 2'd2);
    out_ready = 4'h0;
    idle(1);
    chk("mid_held", {28'b0, out_valid}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {28'b0, out_valid}, 32'h0);
    chk("mid_in_ready", {31'b0, in_ready}, 32'h0);
    chk("mid_cnt", pkt_cnt, 32'h0);
    chk("mid_pending", 32'(sb_q.size()), 32'h1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 4'hF;
    send(8'hC1, 2'd1, 1'b0, 2'd1);
    send(8'hC2, 2'd3, 1'b1, 2'd1);
    idle(3);
    chk("post_rst_cnt", pkt_cnt, 32'h0000_0100);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
